// File: rtl/cordic_arbiter_if.sv
// Client request/response and CORDIC pipeline signal bundle for cordic_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface cordic_arbiter_if #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned SECTOR_FLAG_WIDTH = 2
);
  logic                         c0_req_valid;
  logic                         c0_req_ready;
  logic [DATA_WIDTH-1:0]        c0_req_degree;
  logic [DATA_WIDTH-1:0]        c0_req_x;
  logic [DATA_WIDTH-1:0]        c0_req_y;
  logic [SECTOR_FLAG_WIDTH-1:0] c0_req_sector;
  logic                         c0_req_arctan;
  logic                         c0_rsp_valid;
  logic                         c0_rsp_ready;
  logic [DATA_WIDTH-1:0]        c0_rsp_degree;
  logic [DATA_WIDTH-1:0]        c0_rsp_x;
  logic [DATA_WIDTH-1:0]        c0_rsp_y;
  logic [SECTOR_FLAG_WIDTH-1:0] c0_rsp_sector;

  logic                         c1_req_valid;
  logic                         c1_req_ready;
  logic [DATA_WIDTH-1:0]        c1_req_degree;
  logic [DATA_WIDTH-1:0]        c1_req_x;
  logic [DATA_WIDTH-1:0]        c1_req_y;
  logic [SECTOR_FLAG_WIDTH-1:0] c1_req_sector;
  logic                         c1_req_arctan;
  logic                         c1_rsp_valid;
  logic                         c1_rsp_ready;
  logic [DATA_WIDTH-1:0]        c1_rsp_degree;
  logic [DATA_WIDTH-1:0]        c1_rsp_x;
  logic [DATA_WIDTH-1:0]        c1_rsp_y;
  logic [SECTOR_FLAG_WIDTH-1:0] c1_rsp_sector;

  logic [DATA_WIDTH-1:0]        pipe_degree_in;
  logic [DATA_WIDTH-1:0]        pipe_x_in;
  logic [DATA_WIDTH-1:0]        pipe_y_in;
  logic [SECTOR_FLAG_WIDTH-1:0] pipe_sector_in;
  logic                         pipe_arctan_en_in;
  logic [DATA_WIDTH-1:0]        pipe_degree_out;
  logic [DATA_WIDTH-1:0]        pipe_x_out;
  logic [DATA_WIDTH-1:0]        pipe_y_out;
  logic [SECTOR_FLAG_WIDTH-1:0] pipe_sector_out;

  logic                         idle;

  modport slave (
    input  c0_req_valid, c0_req_degree, c0_req_x, c0_req_y, c0_req_sector, c0_req_arctan,
    output c0_req_ready,
    input  c0_rsp_ready,
    output c0_rsp_valid, c0_rsp_degree, c0_rsp_x, c0_rsp_y, c0_rsp_sector,
    input  c1_req_valid, c1_req_degree, c1_req_x, c1_req_y, c1_req_sector, c1_req_arctan,
    output c1_req_ready,
    input  c1_rsp_ready,
    output c1_rsp_valid, c1_rsp_degree, c1_rsp_x, c1_rsp_y, c1_rsp_sector,
    output pipe_degree_in, pipe_x_in, pipe_y_in, pipe_sector_in, pipe_arctan_en_in,
    input  pipe_degree_out, pipe_x_out, pipe_y_out, pipe_sector_out,
    output idle
  );

  modport master (
    output c0_req_valid, c0_req_degree, c0_req_x, c0_req_y, c0_req_sector, c0_req_arctan,
    input  c0_req_ready,
    output c0_rsp_ready,
    input  c0_rsp_valid, c0_rsp_degree, c0_rsp_x, c0_rsp_y, c0_rsp_sector,
    output c1_req_valid, c1_req_degree, c1_req_x, c1_req_y, c1_req_sector, c1_req_arctan,
    input  c1_req_ready,
    output c1_rsp_ready,
    input  c1_rsp_valid, c1_rsp_degree, c1_rsp_x, c1_rsp_y, c1_rsp_sector,
    input  pipe_degree_in, pipe_x_in, pipe_y_in, pipe_sector_in, pipe_arctan_en_in,
    output pipe_degree_out, pipe_x_out, pipe_y_out, pipe_sector_out,
    input  idle
  );
endinterface

// File: rtl/cordic_arbiter.sv
// Two-client scheduler for a fixed-latency CORDIC pipeline: owner tags track in-flight ops,
// credits gate issue into per-client response FIFOs. Define CORDIC_ARB_FIXED_PRIO_EN for fixed priority.
module cordic_arbiter #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned SECTOR_FLAG_WIDTH = 2,
  parameter int unsigned PIPE_LATENCY      = 6,
  parameter int unsigned RSP_FIFO_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  cordic_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(RSP_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {CLIENT0 = 1'b0, CLIENT1 = 1'b1} client_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]        degree;
    logic [DATA_WIDTH-1:0]        x;
    logic [DATA_WIDTH-1:0]        y;
    logic [SECTOR_FLAG_WIDTH-1:0] sector;
  } result_t;

  typedef struct packed {
    result_t op;
    logic    arctan;
  } request_t;

  typedef struct packed {
    logic    valid;
    client_e owner;
  } tag_t;

  logic [1:0]    req_valid;
  logic [1:0]    rsp_ready;
  logic [1:0]    eligible;
  logic [1:0]    grant;
  logic [1:0]    push;
  logic [1:0]    pop;
  request_t      req [2];
  request_t      issue;
  result_t       pipe_result;
  result_t       rsp_head [2];
  tag_t          tag_last;

  logic [CW-1:0] occ_q  [2];
  logic [CW-1:0] cnt_q  [2];
  logic [PW-1:0] head_q [2];
  logic [PW-1:0] tail_q [2];
  result_t       mem_q  [2][RSP_FIFO_DEPTH];
  tag_t          tag_q  [PIPE_LATENCY];

  assign req_valid = {bus.c1_req_valid, bus.c0_req_valid};
  assign rsp_ready = {bus.c1_rsp_ready, bus.c0_rsp_ready};
  assign req[0] = {bus.c0_req_degree, bus.c0_req_x, bus.c0_req_y, bus.c0_req_sector, bus.c0_req_arctan};
  assign req[1] = {bus.c1_req_degree, bus.c1_req_x, bus.c1_req_y, bus.c1_req_sector, bus.c1_req_arctan};
  assign pipe_result = {bus.pipe_degree_out, bus.pipe_x_out, bus.pipe_y_out, bus.pipe_sector_out};

  // occ_q counts ops granted but not yet popped, i.e. FIFO count plus owned in-flight tags.
  assign eligible[0] = req_valid[0] && (occ_q[0] < CW'(RSP_FIFO_DEPTH));
  assign eligible[1] = req_valid[1] && (occ_q[1] < CW'(RSP_FIFO_DEPTH));

`ifdef CORDIC_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    if (eligible[0]) begin
      grant[0] = 1'b1;
    end else if (eligible[1]) begin
      grant[1] = 1'b1;
    end
  end
`else
  client_e last_q;
  client_e last_d;

  always_comb begin
    grant  = eligible;
    last_d = last_q;
    if (&eligible) begin
      grant = (last_q == CLIENT1) ? 2'b01 : 2'b10;
    end
    if (grant[0]) begin
      last_d = CLIENT0;
    end else if (grant[1]) begin
      last_d = CLIENT1;
    end
  end

  // Reset to CLIENT1 so client 0 wins the first conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= CLIENT1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    issue = '0;
    if (grant[0]) begin
      issue = req[0];
    end else if (grant[1]) begin
      issue = req[1];
    end
  end

  assign bus.c0_req_ready      = grant[0];
  assign bus.c1_req_ready      = grant[1];
  assign bus.pipe_degree_in    = issue.op.degree;
  assign bus.pipe_x_in         = issue.op.x;
  assign bus.pipe_y_in         = issue.op.y;
  assign bus.pipe_sector_in    = issue.op.sector;
  assign bus.pipe_arctan_en_in = issue.arctan;

  assign tag_last = tag_q[PIPE_LATENCY-1];
  assign push[0]  = tag_last.valid && (tag_last.owner == CLIENT0);
  assign push[1]  = tag_last.valid && (tag_last.owner == CLIENT1);
  assign pop[0]   = (cnt_q[0] != '0) && rsp_ready[0];
  assign pop[1]   = (cnt_q[1] != '0) && rsp_ready[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < PIPE_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
      for (int unsigned n = 0; n < 2; n++) begin
        occ_q[n]  <= '0;
        cnt_q[n]  <= '0;
        head_q[n] <= '0;
        tail_q[n] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: |grant, owner: (grant[1] ? CLIENT1 : CLIENT0)};
      for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      for (int unsigned n = 0; n < 2; n++) begin
        occ_q[n] <= occ_q[n] + CW'(grant[n]) - CW'(pop[n]);
        cnt_q[n] <= cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
        if (push[n]) begin
          tail_q[n] <= tail_q[n] + PW'(1);
        end
        if (pop[n]) begin
          head_q[n] <= head_q[n] + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < 2; n++) begin
      if (push[n]) begin
        mem_q[n][tail_q[n]] <= pipe_result;
      end
    end
  end

  // Data is forced to zero while empty so the storage itself needs no reset.
  always_comb begin
    for (int unsigned n = 0; n < 2; n++) begin
      rsp_head[n] = '0;
      if (cnt_q[n] != '0) begin
        rsp_head[n] = mem_q[n][head_q[n]];
      end
    end
  end

  assign bus.c0_rsp_valid = (cnt_q[0] != '0);
  assign bus.c1_rsp_valid = (cnt_q[1] != '0);
  assign {bus.c0_rsp_degree, bus.c0_rsp_x, bus.c0_rsp_y, bus.c0_rsp_sector} = rsp_head[0];
  assign {bus.c1_rsp_degree, bus.c1_rsp_x, bus.c1_rsp_y, bus.c1_rsp_sector} = rsp_head[1];

  assign bus.idle = (occ_q[0] == '0) && (occ_q[1] == '0);
endmodule
